// File: rtl/nand_seq_alu_if.sv
// Bus between the ALU control, the sequencer and the external shared NAND gate.
// The master side issues requests; the slave side is the sequencer itself.
interface nand_seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] nand_a;
  logic [WIDTH-1:0] nand_b;
  logic [WIDTH-1:0] nand_c;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] y;

  modport master (
    output start, op, a, b, nand_c,
    input  nand_a, nand_b, busy, done, err, y
  );

  modport slave (
    input  start, op, a, b, nand_c,
    output nand_a, nand_b, busy, done, err, y
  );
endinterface

// File: rtl/nand_seq_alu.sv
// Multi-cycle logic unit built on one shared external WIDTH-bit NAND gate.
// Each RUN cycle routes two registered sources to the NAND and captures its
// output into a temp or into y; the op decides the step sequence.
module nand_seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  nand_seq_alu_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    SRC_RA,
    SRC_RB,
    SRC_T1,
    SRC_T2,
    SRC_T3
  } src_e;

  typedef enum logic [1:0] {
    DST_T1,
    DST_T2,
    DST_T3,
    DST_Y
  } dst_e;

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  state_e           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [2:0]       rop_q, rop_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] t1_q, t1_d;
  logic [WIDTH-1:0] t2_q, t2_d;
  logic [WIDTH-1:0] t3_q, t3_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Current step decode
  src_e             sel_a, sel_b;
  dst_e             dst;
  logic             last_step;
  logic [WIDTH-1:0] nand_a_c, nand_b_c;

  function automatic logic [WIDTH-1:0] pick(input src_e s,
                                            input logic [WIDTH-1:0] ra, rb, t1, t2, t3);
    case (s)
      SRC_RA:  pick = ra;
      SRC_RB:  pick = rb;
      SRC_T1:  pick = t1;
      SRC_T2:  pick = t2;
      default: pick = t3;
    endcase
  endfunction

  // Step table: NAND operand sources, capture target and last-step flag per (op, step)
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    sel_a     = SRC_RA;
    sel_b     = SRC_RB;
    dst       = DST_Y;
    last_step = 1'b1;
    case (rop_q)
      3'b000: begin                                   // NAND
        sel_a = SRC_RA; sel_b = SRC_RB; dst = DST_Y;
      end
      3'b001: begin                                   // NOT A
        sel_a = SRC_RA; sel_b = SRC_RA; dst = DST_Y;
      end
      3'b010: begin                                   // AND
        case (step_q)
          3'd0:    begin sel_a = SRC_RA; sel_b = SRC_RB; dst = DST_T1; last_step = 1'b0; end
          default: begin sel_a = SRC_T1; sel_b = SRC_T1; dst = DST_Y; end
        endcase
      end
      3'b011, 3'b100: begin                           // OR, NOR
        case (step_q)
          3'd0: begin sel_a = SRC_RA; sel_b = SRC_RA; dst = DST_T1; last_step = 1'b0; end
          3'd1: begin sel_a = SRC_RB; sel_b = SRC_RB; dst = DST_T2; last_step = 1'b0; end
          3'd2: begin
            sel_a = SRC_T1; sel_b = SRC_T2;
            if (rop_q == 3'b011) begin
              dst = DST_Y;
            end else begin
              dst = DST_T3; last_step = 1'b0;
            end
          end
          default: begin sel_a = SRC_T3; sel_b = SRC_T3; dst = DST_Y; end
        endcase
      end
      3'b101, 3'b110: begin                           // XOR, XNOR
        case (step_q)
          3'd0: begin sel_a = SRC_RA; sel_b = SRC_RB; dst = DST_T1; last_step = 1'b0; end
          3'd1: begin sel_a = SRC_RA; sel_b = SRC_T1; dst = DST_T2; last_step = 1'b0; end
          3'd2: begin sel_a = SRC_RB; sel_b = SRC_T1; dst = DST_T3; last_step = 1'b0; end
          3'd3: begin
            sel_a = SRC_T2; sel_b = SRC_T3;
            if (rop_q == 3'b101) begin
              dst = DST_Y;
            end else begin
              dst = DST_T1; last_step = 1'b0;
            end
          end
          default: begin sel_a = SRC_T1; sel_b = SRC_T1; dst = DST_Y; end
        endcase
      end
      default: ;                                      // illegal op never enters RUN
    endcase
  end

  // NAND operands: routed sources while running, parked at zero otherwise
  always_comb begin
    nand_a_c = '0;
    nand_b_c = '0;
    if (state_q == S_RUN) begin
      nand_a_c = pick(sel_a, ra_q, rb_q, t1_q, t2_q, t3_q);
      nand_b_c = pick(sel_b, ra_q, rb_q, t1_q, t2_q, t3_q);
    end
  end

  // Next-state logic for the FSM, operand latches, temps and registered outputs
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rop_d   = rop_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    t3_d    = t3_q;
    y_d     = y_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ra_d   = bus.a;
          rb_d   = bus.b;
          rop_d  = bus.op;
          step_d = 3'd0;
          if (bus.op == OP_ILLEGAL) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            y_d     = '0;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        case (dst)
          DST_T1:  t1_d = bus.nand_c;
          DST_T2:  t2_d = bus.nand_c;
          DST_T3:  t3_d = bus.nand_c;
          default: y_d  = bus.nand_c;
        endcase
        if (last_step) begin
          state_d = S_DONE;
          step_d  = 3'd0;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + 3'd1;
          busy_d = 1'b1;
        end
      end
      default: begin                                  // S_DONE
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset that overrides everything
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample its _d value from
    // before the edge; blocking ones here would create order-dependent races.
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      rop_q   <= 3'd0;
      ra_q    <= '0;
      rb_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      t3_q    <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rop_q   <= rop_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      t3_q    <= t3_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.nand_a = nand_a_c;
  assign bus.nand_b = nand_b_c;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.y      = y_q;

endmodule

// File: tb/tb_nand_seq_alu.sv
// Self-checking bench for nand_seq_alu: directed cases plus random ops,
// compared against a plain bitwise-arithmetic reference model.
module tb_nand_seq_alu;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  nand_seq_alu_if #(.WIDTH(W)) bus ();

  // The external shared NAND gate
  assign bus.nand_c = ~(bus.nand_a & bus.nand_b);

  nand_seq_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the logic function each op is meant to compute
  function automatic logic [W-1:0] model_y(input logic [2:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  model_y = ~(a & b);
      3'b001:  model_y = ~a;
      3'b010:  model_y = a & b;
      3'b011:  model_y = a | b;
      3'b100:  model_y = ~(a | b);
      3'b101:  model_y = a ^ b;
      3'b110:  model_y = ~(a ^ b);
      default: model_y = '0;
    endcase
  endfunction

  function automatic int model_n(input logic [2:0] op);
    case (op)
      3'b000, 3'b001: model_n = 1;
      3'b010:         model_n = 2;
      3'b011:         model_n = 3;
      3'b100, 3'b101: model_n = 4;
      3'b110:         model_n = 5;
      default:        model_n = 0;
    endcase
  endfunction

  // Issue one request and watch a bounded window of N+3 cycles afterwards.
  // inj_cyc: busy cycle on which a stray start/op/a/b change is driven (0 = none).
  // rst_cyc: busy cycle on which rst is asserted for one edge (0 = none).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj_cyc, input int rst_cyc, input bit chk_trace);
    int n, busy_cnt, done_cnt, done_at;
    logic [W-1:0] y_at_done, idle_nand, exp_y;
    logic err_at_done, err_stray;
    logic [W-1:0] ta[$];
    logic [W-1:0] tb_q[$];
    logic [W-1:0] t1, t2, t3;
    n = model_n(op);
    exp_y = model_y(op, a, b);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    y_at_done = '0; idle_nand = '0; err_at_done = 1'b0; err_stray = 1'b0;

    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom); bus.a = W'($urandom); bus.b = W'($urandom);

    for (int i = 1; i <= n + 3; i++) begin
      @(negedge clk);
      if (bus.busy) begin
        busy_cnt++;
        ta.push_back(bus.nand_a);
        tb_q.push_back(bus.nand_b);
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at     = i;
          y_at_done   = bus.y;
          err_at_done = bus.err;
          idle_nand   = bus.nand_a | bus.nand_b;
        end
      end else if (bus.err) begin
        err_stray = 1'b1;
      end
      if (rst_cyc != 0 && i == rst_cyc + 1) begin
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_done", 32'(bus.done), 32'd0);
        check("post_rst_y",    32'(bus.y),    32'd0);
      end
      if (i == inj_cyc) begin
        bus.start = 1'b1; bus.op = 3'b000; bus.a = W'($urandom); bus.b = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      rst = (i == rst_cyc) ? 1'b1 : 1'b0;
    end

    if (rst_cyc != 0) begin
      check("rst_done_cnt", 32'(done_cnt), 32'd0);
      check("rst_busy_cnt", 32'(busy_cnt), 32'(rst_cyc));
      check("rst_y_hold",   32'(bus.y),    32'd0);
    end else begin
      check($sformatf("op%0d_busy_cnt", op), 32'(busy_cnt), 32'(n));
      check($sformatf("op%0d_done_cnt", op), 32'(done_cnt), 32'd1);
      check($sformatf("op%0d_done_at", op),  32'(done_at),  32'(n + 1));
      check($sformatf("op%0d_y", op),        32'(y_at_done), 32'(exp_y));
      check($sformatf("op%0d_err", op),      32'(err_at_done), 32'(op == 3'b111));
      check($sformatf("op%0d_y_hold", op),   32'(bus.y),    32'(exp_y));
      check($sformatf("op%0d_idle_nand", op), 32'(idle_nand), 32'd0);
      check($sformatf("op%0d_err_stray", op), 32'(err_stray), 32'd0);
    end

    if (chk_trace) begin
      // XOR/XNOR operand pairs follow from the NAND-only decomposition of XOR
      t1 = ~(a & b);
      t2 = ~(a & t1);
      t3 = ~(b & t1);
      check("trace_len", 32'(ta.size()), 32'(n));
      if (ta.size() >= 4) begin
        check("trace0", {ta[0], tb_q[0]}, {a, b});
        check("trace1", {ta[1], tb_q[1]}, {a, t1});
        check("trace2", {ta[2], tb_q[2]}, {b, t1});
        check("trace3", {ta[3], tb_q[3]}, {t2, t3});
      end
    end
  endtask

  initial begin
    logic [2:0] rop;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    check("rst_y",      32'(bus.y),      32'd0);
    check("rst_nand_a", 32'(bus.nand_a), 32'd0);
    check("rst_nand_b", 32'(bus.nand_b), 32'd0);
    rst = 1'b0;

    // Directed: every op on the reference operands
    run_op(3'b000, 8'hC3, 8'hA5, 0, 0, 1'b0);
    check("tp_nand_value", 32'(bus.y), 32'h7E);
    run_op(3'b001, 8'hC3, 8'hA5, 0, 0, 1'b0);
    check("tp_not_value", 32'(bus.y), 32'h3C);
    run_op(3'b010, 8'hC3, 8'hA5, 0, 0, 1'b0);
    run_op(3'b011, 8'hC3, 8'hA5, 0, 0, 1'b0);
    run_op(3'b100, 8'hC3, 8'hA5, 0, 0, 1'b0);
    run_op(3'b101, 8'hC3, 8'hA5, 0, 0, 1'b1);
    check("tp_xor_value", 32'(bus.y), 32'h66);
    run_op(3'b110, 8'hC3, 8'hA5, 0, 0, 1'b1);
    check("tp_xnor_value", 32'(bus.y), 32'h99);

    // Illegal op, then a legal op must clear err
    run_op(3'b111, 8'hC3, 8'hA5, 0, 0, 1'b0);
    run_op(3'b010, 8'hC3, 8'hA5, 0, 0, 1'b0);

    // Stray start and operand change on the 2nd busy cycle of XOR
    run_op(3'b101, 8'hC3, 8'hA5, 2, 0, 1'b0);
    check("inject_xor_value", 32'(bus.y), 32'h66);

    // Reset on the 3rd busy cycle of XNOR, then a normal op
    run_op(3'b110, 8'hC3, 8'hA5, 0, 3, 1'b0);
    run_op(3'b110, 8'hC3, 8'hA5, 0, 0, 1'b0);

    // Boundary operands
    run_op(3'b101, 8'h00, 8'hFF, 0, 0, 1'b1);
    run_op(3'b011, 8'h00, 8'h00, 0, 0, 1'b0);
    run_op(3'b010, 8'hFF, 8'hFF, 0, 0, 1'b0);

    // Random ops and operands
    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      run_op(rop, W'($urandom), W'($urandom), 0, 0, (rop == 3'b101 || rop == 3'b110));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard bound so the run always ends even if a wait goes wrong
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/nand_seq_alu.md
Name: nand_seq_alu

Overview:
- Multi-cycle controller that computes bitwise logic functions using only one shared WIDTH-bit NAND resource.
- Issues one NAND evaluation per cycle and stores intermediates in internal temp registers.
- Returns the result with a start/busy/done handshake.
- Sits between the course ALU control and the existing NAND gate. The NAND is instantiated outside the block and reached through the nand_* ports.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 1..32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation select, latched with start.
- a  input  WIDTH  operand A, latched with start.
- b  input  WIDTH  operand B, latched with start.
- nand_a  output  WIDTH  first input to the shared NAND.
- nand_b  output  WIDTH  second input to the shared NAND.
- nand_c  input  WIDTH  shared NAND output; combinational, equal to ~(nand_a & nand_b) in the same cycle.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when y is valid.
- err  output  1  high with done when op was illegal.
- y  output  WIDTH  result register; holds its value until the next done.

Behaviour:
- Reset, synchronous: state=IDLE, step=0, busy=0, done=0, err=0, y=0, temps=0. nand_a=nand_b=0 while in IDLE/DONE.
- Reset wins over every other event, including mid-RUN. The operation is abandoned with no done pulse, and y returns to 0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On start=1, latch a, b and op into ra, rb and rop, set step=0, and go to RUN.
  - If op=111, go directly to DONE with err=1 and y=0.
- RUN: each cycle drives nand_a/nand_b from the table below for the current step and captures nand_c at the edge. On the last step, the captured value goes into y and the FSM moves to DONE. Otherwise step increments.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. err is valid only while done=1, otherwise 0.
- start is ignored in RUN and DONE, with no queuing. Minimum spacing between accepted starts is N+2 cycles.
- Latency: start accepted at edge k gives done high in the cycle after edge k+N, where N is the step count. busy is high for exactly N cycles.
- Step sequences (t1/t2/t3 are temps; "->" means captured at the edge):
  - 000 NAND, N=1: (ra,rb)->y.
  - 001 NOT A, N=1: (ra,ra)->y.
  - 010 AND, N=2: (ra,rb)->t1; (t1,t1)->y.
  - 011 OR, N=3: (ra,ra)->t1; (rb,rb)->t2; (t1,t2)->y.
  - 100 NOR, N=4: OR steps with the third result ->t3; then (t3,t3)->y.
  - 101 XOR, N=4: (ra,rb)->t1; (ra,t1)->t2; (rb,t1)->t3; (t2,t3)->y.
  - 110 XNOR, N=5: XOR steps with the fourth result ->t1; then (t1,t1)->y.
  - 111: illegal, N=0. err=1, y=0.
- Input changes:
  - Changes to a, b and op after acceptance have no effect.
  - nand_c is not sampled outside RUN.
- Step counter is 3 bits. The maximum step index is 4, so it never wraps.

Test Plan:
1. WIDTH=8, a=8'hC3, b=8'hA5, op=000 -> busy for 1 cycle, done next cycle, y=8'h7E. Then op=001 -> y=8'h3C, 1 busy cycle.
2. Same operands: op=010 -> y=8'h81 after 2 busy cycles. op=011 -> y=8'hE7 after 3. op=100 -> y=8'h18 after 4.
3. Same operands: op=101 -> y=8'h66 after 4 busy cycles; check nand_a/nand_b per step = (C3,A5),(C3,7E),(A5,7E),(BD,DB). op=110 -> y=8'h99 after 5.
4. op=111 -> no busy, done=1 with err=1 and y=8'h00 one cycle after the start edge. The next legal op returns err=0.
5. Start XOR, then pulse start with op=000 and change a/b on the 2nd busy cycle -> ignored; y=8'h66; only one done pulse.
6. Start XNOR, assert rst on the 3rd busy cycle -> next cycle busy=0, done=0, y=0, and no done pulse afterwards. A new start after rst deasserts completes normally.
